mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares the existing 4:1 bit multiplexer `mux_4x1` between four requesters. It accepts per-requester requests and grants exactly one at a time. It drives the mux select lines from the grant and registers the selected data bit as a single output stream. A hold limit forces rotation, so a persistent requester cannot starve the others.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/mux_4x1.sv | 17 +
 rtl/rr_pick4.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Purpose: shared types and constants for the round-robin mux arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, requester count, select width, one-hot helper.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Decode a requester index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// Purpose: plain 4:1 bit multiplexer shared by the four requesters.
// Latency: combinational.
// Backpressure: none.
// Ports: d0..d3 data inputs, s1:s0 select, y selected bit.
module mux_4x1 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic s0,
    input  logic s1,
    output logic y
);

    assign y = s1 ? (s0 ? d3 : d2) : (s0 ? d1 : d0);

endmodule

// File: rtl/rr_pick4.sv
// Purpose: round-robin picker; first set bit of req & ~excl searching from ptr upward (mod 4).
// Latency: combinational.
// Backpressure: none; found=0 when no eligible requester.
// Ports: req/excl request and exclude masks, ptr start index, found/idx result.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] excl,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & ~excl;

    // Walk from the farthest offset down to ptr so the closest match wins last.
    always_comb begin
        found = |cand;
        idx   = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[ptr + SEL_W'(i)]) begin
                idx = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin arbiter sharing mux_4x1 among 4 requesters, with a hold limit forcing rotation.
// Latency: req -> gnt/sel/busy 1 edge, req -> y 2 edges.
// Backpressure: a requester keeps its grant at most MAX_HOLD cycles while others are pending.
// Ports: clk, rst_n, req[3:0], d[3:0] in; gnt[3:0], sel[1:0], busy, y out (all registered but busy=|gnt).
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] d,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               y
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    arb_state_t         state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt, sel_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, excl;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               cur_req;
    logic               take;
    logic               mux_out;

    // While granting, the current owner is masked out, so pick_found means
    // "someone else is pending" and pick_idx is the next owner for both the
    // release switch and the forced rotation.
    assign excl    = (state == GRANT) ? onehot(sel) : '0;
    assign cur_req = (state == GRANT) && req[sel];

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        take      = 1'b0;

        if (state == IDLE) begin
            take = pick_found;
        end else begin
            if (!cur_req || (cnt == HOLD_LIM)) begin
                take = pick_found;
            end
            if (!cur_req && !pick_found) begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end else if (cur_req && !take && (cnt != HOLD_LIM)) begin
                cnt_nxt = cnt + 4'd1;
            end
        end

        if (take) begin
            state_nxt = GRANT;
            gnt_nxt   = onehot(pick_idx);
            sel_nxt   = pick_idx;
            ptr_nxt   = pick_idx + SEL_W'(1);
            cnt_nxt   = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
        end
    end

    assign busy = |gnt;

    mux_4x1 u_mux (
        .d0 (d[0]),
        .d1 (d[1]),
        .d2 (d[2]),
        .d3 (d[3]),
        .s0 (sel[0]),
        .s1 (sel[1]),
        .y  (mux_out)
    );

    // Output bit samples the mux driven by the registered select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= 1'b0;
        end else begin
            y <= busy ? mux_out : 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD   = 4;
    localparam int WAIT_BOUND = 3 * MAX_HOLD + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: owner index (-1 idle), priority pointer, run length.
    int   m_owner;
    int   m_ptr;
    int   m_run;
    int   m_sel;
    logic m_y;
    int   wait_c[4];
    logic [3:0] req_s;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_run   = 0;
        m_sel   = 0;
        m_y     = 1'b0;
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
    endtask

    // One rising edge of the specified behaviour, from the inputs seen at that edge.
    task automatic model_step();
        logic [3:0] others;
        int         cand;
        m_y    = (m_owner >= 0) ? d[m_sel] : 1'b0;
        others = req;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        cand = 0;
        if (m_owner >= 0 && req[m_owner] && !(m_run == MAX_HOLD && others != 4'b0)) begin
            if (m_run < MAX_HOLD) m_run++;
        end else if (others != 4'b0) begin
            for (int k = 3; k >= 0; k--) begin
                if (others[(m_ptr + k) % 4]) cand = (m_ptr + k) % 4;
            end
            m_owner = cand;
            m_ptr   = (cand + 1) % 4;
            m_run   = 1;
            m_sel   = cand;
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_gnt;
        int         worst;
        @(posedge clk);
        req_s = req;
        model_step();
        #1;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        check("gnt", gnt, exp_gnt);
        check("sel", {2'b00, sel}, 4'(m_sel));
        check("busy", {3'b000, busy}, {3'b000, (m_owner >= 0)});
        check("y", {3'b000, y}, {3'b000, m_y});
        worst = 0;
        for (int i = 0; i < 4; i++) begin
            if (req_s[i] && !gnt[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > worst) worst = wait_c[i];
        end
        check("wait_bound", {3'b000, (worst <= WAIT_BOUND)}, 4'b0001);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_gnt", gnt, 4'b0000);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] dpat;
        int         idx;

        rst_n = 1'b0;
        req   = 4'b0;
        d     = 4'b0;
        model_reset();
        #12;
        check("reset_gnt", gnt, 4'b0000);
        check("reset_sel", {2'b00, sel}, 4'b0000);
        check("reset_busy", {3'b000, busy}, 4'b0000);
        check("reset_y", {3'b000, y}, 4'b0000);
        rst_n = 1'b1;

        // Single requester: grant after one edge, data after two.
        req = 4'b0010;
        d   = 4'b0010;
        tick();
        check("single_gnt", gnt, 4'b0010);
        check("single_sel", {2'b00, sel}, 4'b0001);
        tick();
        check("single_y", {3'b000, y}, 4'b0001);
        req = 4'b0000;
        tick();
        check("single_rel_busy", {3'b000, busy}, 4'b0000);
        tick();
        check("single_rel_y", {3'b000, y}, 4'b0000);

        // Reset in the middle of a grant.
        req = 4'b0100;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", gnt, 4'b0000);
        check("midrst_busy", {3'b000, busy}, 4'b0000);
        check("midrst_y", {3'b000, y}, 4'b0000);
        model_reset();
        #1;
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        check("postrst_gnt", gnt, 4'b0001);

        // All four requesting from ptr=0: 0,1,2,3,0 with MAX_HOLD cycles each.
        pulse_reset();
        req  = 4'b1111;
        d    = 4'b1010;
        dpat = d;
        for (int t = 1; t <= 17; t++) begin
            tick();
            idx = ((t - 1) / MAX_HOLD) % 4;
            check("rot_gnt", gnt, 4'(1 << idx));
            if (t >= 2) begin
                idx = ((t - 2) / MAX_HOLD) % 4;
                check("steer_y", {3'b000, y}, {3'b000, dpat[idx]});
            end
        end

        // Switch to index 3, then release it with index 0 pending.
        req = 4'b1000;
        tick();
        check("wrap_gnt3", gnt, 4'b1000);
        req = 4'b1001;
        tick();
        req = 4'b0001;
        tick();
        check("wrap_gnt0", gnt, 4'b0001);
        check("wrap_sel", {2'b00, sel}, 4'b0000);
        check("wrap_busy", {3'b000, busy}, 4'b0001);

        // Lone requester holds indefinitely; contention then forces rotation.
        req = 4'b0100;
        for (int t = 0; t < 20; t++) begin
            tick();
            check("hold_gnt", gnt, 4'b0100);
        end
        req = 4'b0101;
        tick();
        check("hold_rot_gnt", gnt, 4'b0001);

        // Random traffic against the model.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
